dma_rd_ctrl: RTL and testbench
==============================

// Module: dma_rd_ctrl
// PURPOSE
// - Read-side DMA stage upstream of the DMA read-data FIFO. On go, issues SIZE word reads from ADDR
//   on an Avalon-MM-style read master and writes each returned word into the FIFO.
// - Credit-based issue uses the FIFO's space output, so the FIFO never overflows and FIFO full is never needed.
// PARAMETERS
// - DATA_WIDTH      512  word width; must equal the FIFO WIDTH
// - ADDR_WIDTH      64   word-address width
// - SIZE_WIDTH      32   transfer-length width, in words
// - FIFO_DEPTH      512  depth of the downstream FIFO; must equal its DEPTH
// - MAX_OUTSTANDING 64   cap on issued-but-unreturned reads; 1 <= MAX_OUTSTANDING <= FIFO_DEPTH
// PORTS
// - clk           in   1                     clock
// - rst_n         in   1                     asynchronous reset, active low
// - go            in   1                     start pulse; sampled only in IDLE or DONE
// - rd_addr       in   ADDR_WIDTH            start word address; latched on accepted go
// - size          in   SIZE_WIDTH            transfer length in words; latched on accepted go
// - done          out  1                     high in DONE
// - mem_rd_en     out  1                     read request
// - mem_rd_addr   out  ADDR_WIDTH            request address
// - mem_waitreq   in   1                     request stalled; request accepted when mem_rd_en && !mem_waitreq
// - mem_rd_valid  in   1                     response valid; responses arrive in order
// - mem_rd_data   in   DATA_WIDTH            response data
// - fifo_wr_en    out  1                     FIFO write
// - fifo_wr_data  out  DATA_WIDTH            FIFO write data
// - fifo_space    in   $clog2(FIFO_DEPTH)+1  FIFO free entries; a write shows in this count 1 cycle later
// - stall_cycles  out  32                    issue-stall counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: state=IDLE; done, mem_rd_en, fifo_wr_en = 0; mem_rd_addr, fifo_wr_data = 0;
//   all internal counters = 0; stall_cycles = 0.
// - FSM states: IDLE, REQ, DRAIN, DONE.
//   - IDLE/DONE + go, size!=0: go to REQ next cycle. Latch addr, req_left=size, resp_left=size. Clear done.
//   - IDLE/DONE + go, size==0: go to DONE next cycle; no requests issued.
//   - REQ, last request accepted: go to DRAIN.
//   - DRAIN, resp_left==0 and no write in flight (pending==0): go to DONE; done=1 from that cycle.
//   - go in REQ or DRAIN is ignored.
// - Issue rule:
//   - pending = accepted requests whose FIFO write is not yet reflected in fifo_space.
//   - pending increments on accept and decrements the cycle after fifo_wr_en=1.
//   - In REQ, mem_rd_en may newly assert only when req_left>0, pending<fifo_space and pending<MAX_OUTSTANDING.
//   - Once asserted, mem_rd_en and mem_rd_addr hold stable until accepted, regardless of credit.
// - On accept: mem_rd_addr increments by 1, wrapping modulo 2^ADDR_WIDTH; req_left decrements.
//   Back-to-back accepts give 1 request per cycle.
// - Response path, 1-cycle latency:
//   - mem_rd_valid at cycle t gives fifo_wr_en=1 at t+1, with fifo_wr_data = mem_rd_data registered at t.
//   - resp_left decrements on each valid.
// - Simultaneous pending inc/dec in one cycle: net 0.
// - mem_rd_valid in IDLE/DONE, or when resp_left==0, is dropped; no FIFO write.
// - Reset mid-transfer: immediate return to IDLE. The FIFO must be reset in the same reset domain.
//   Late memory responses after reset are dropped by the rule above.
// - Counters: req_left and resp_left are SIZE_WIDTH bits. pending is $clog2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.
// CONFIGURATION
// - Macro DMA_RD_PERF_EN defined:
//   - stall_cycles increments each REQ cycle with req_left>0 and no accept (credit stall or mem_waitreq).
//   - Saturates at 32'hFFFFFFFF; cleared to 0 on accepted go.
// - Macro undefined: stall_cycles tied to 0; no counter logic.
// TESTING
// - Size 1 at addr 0x100, fifo_space=512, no waitreq, 3-cycle memory latency:
//   - one request, addr 0x100; one FIFO write; done=1 after the write is reflected; stall_cycles=0.
// - Size 1000, FIFO_DEPTH=512, no FIFO reads for the first 2000 cycles:
//   - exactly 512 writes occur, issue stops, and fifo_space never underflows.
//   - draining the FIFO resumes issue; done after 1000 writes.
// - mem_waitreq high 5 cycles on the 3rd request:
//   - mem_rd_en and mem_rd_addr stay stable for those 5 cycles; addresses stay sequential.
//   - with DMA_RD_PERF_EN, stall_cycles=5.
// - Start addr 2^ADDR_WIDTH-2, size 4: addresses issued are ...FE, ...FF, 0, 1.
// - size=0 go: done=1 next cycle, mem_rd_en stays 0.
//   - A second go while in REQ is ignored: request count equals the first size.
// - rst_n low mid-DRAIN with 3 responses outstanding: outputs return to reset values immediately.
//   - After rst_n rises, those late responses produce no fifo_wr_en.

Source files
------------

// File: rtl/dma_rd_ctrl.sv
// ---------------------------------------------------------------------------
// dma_rd_ctrl
// Read side of the DMA engine. A go pulse starts a transfer of `size` words
// from `rd_addr`; reads are issued on an Avalon-MM style master and every
// returned word is written into the downstream read-data FIFO. Requests are
// only issued when the FIFO is guaranteed to have room for the response, so
// the FIFO can never overflow and its full flag is not needed.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   go                start pulse (honoured only in IDLE or DONE)
//   rd_addr, size     transfer start word address and length in words
//   done              high while in DONE
//   mem_rd_en/addr    read request; accepted when mem_rd_en && !mem_waitreq
//   mem_waitreq       memory stall
//   mem_rd_valid/data in-order read responses
//   fifo_wr_en/data   FIFO write port, one cycle after each response
//   fifo_space        FIFO free entries (a write shows up one cycle later)
//   stall_cycles      issue-stall counter
//
// Optional feature: define DMA_RD_PERF_EN to build the stall_cycles counter;
// without it stall_cycles is tied to zero.
// ---------------------------------------------------------------------------
module dma_rd_ctrl #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int SIZE_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 512,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          go,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [SIZE_WIDTH-1:0]         size,
    output logic                          done,
    output logic                          mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
    input  logic                          mem_waitreq,
    input  logic                          mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_space,
    output logic [31:0]                   stall_cycles
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SIZE_WIDTH-1:0] req_left_q, req_left_d;
    logic [SIZE_WIDTH-1:0] resp_left_q, resp_left_d;
    logic [PW-1:0]         pending_q, pending_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                  accept;
    logic                  resp_ok;
    logic                  credit_ok;
    logic [PW:0]           committed;

    // Credit is judged for the cycle in which a new request would appear.
    // pending_q plus this cycle's accept counts every request whose word is
    // not yet visible in fifo_space (a write in flight is still in pending_q),
    // so pending + occupied never exceeds FIFO_DEPTH.
    always_comb begin
        accept    = rd_en_q && !mem_waitreq;
        resp_ok   = mem_rd_valid && (resp_left_q != '0) &&
                    ((state_q == REQ) || (state_q == DRAIN));
        committed = {1'b0, pending_q} + (PW + 1)'(accept);
        credit_ok = (committed < {1'b0, fifo_space}) &&
                    (committed < (PW + 1)'(MAX_OUTSTANDING));
    end

    // Next-state logic: FSM, request issue, response capture, credit count.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        req_left_d  = req_left_q;
        resp_left_d = resp_left_q;
        rd_en_d     = 1'b0;
        wr_en_d     = resp_ok;
        wr_data_d   = wr_data_q;
        pending_d   = pending_q + PW'(accept) - PW'(wr_en_q);

        if (resp_ok) begin
            wr_data_d   = mem_rd_data;
            resp_left_d = resp_left_q - SIZE_WIDTH'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    if (size != '0) begin
                        state_d     = REQ;
                        addr_d      = rd_addr;
                        req_left_d  = size;
                        resp_left_d = size;
                        // First request goes out on the first REQ cycle.
                        rd_en_d     = credit_ok;
                    end else begin
                        state_d     = DONE;
                        req_left_d  = '0;
                        resp_left_d = '0;
                    end
                end
            end
            REQ: begin
                if (accept) begin
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    req_left_d = req_left_q - SIZE_WIDTH'(1);
                end
                // A stalled request holds regardless of credit.
                if (rd_en_q && !accept) begin
                    rd_en_d = 1'b1;
                end else begin
                    rd_en_d = (req_left_d != '0) && credit_ok;
                end
                if (accept && (req_left_q == SIZE_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((resp_left_q == '0) && (pending_q == '0)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            req_left_q  <= '0;
            resp_left_q <= '0;
            pending_q   <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_left_q  <= req_left_d;
            resp_left_q <= resp_left_d;
            pending_q   <= pending_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
        end
    end

`ifdef DMA_RD_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Count REQ cycles that still owe requests but got none accepted,
    // whether from lack of credit or from mem_waitreq. Saturating.
    always_comb begin
        stall_d = stall_q;
        if (((state_q == IDLE) || (state_q == DONE)) && go) begin
            stall_d = '0;
        end else if ((state_q == REQ) && (req_left_q != '0) && !accept &&
                     (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign done         = (state_q == DONE);
    assign mem_rd_en    = rd_en_q;
    assign mem_rd_addr  = addr_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;

endmodule

// File: tb/tb_dma_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_rd_ctrl
// Directed bench for dma_rd_ctrl with a small memory model (fixed latency,
// programmable wait-request burst) and a FIFO occupancy model that drives
// fifo_space.
// ---------------------------------------------------------------------------
module tb_dma_rd_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int SW    = 32;
    localparam int DEPTH = 512;
    localparam int PW    = $clog2(DEPTH) + 1;

`ifdef DMA_RD_PERF_EN
    localparam logic [31:0] EXP_WAIT_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_WAIT_STALL = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [SW-1:0] size = '0;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_waitreq;
    logic          mem_rd_valid = 1'b0;
    logic [DW-1:0] mem_rd_data = '0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic [PW-1:0] fifo_space;
    logic [31:0]   stall_cycles;

    int checks = 0;
    int failures = 0;

    dma_rd_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
        .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .rd_addr(rd_addr), .size(size),
        .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_waitreq(mem_waitreq), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .fifo_space(fifo_space),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } req_t;

    req_t          req_q[$];
    req_t          new_req;
    logic [AW-1:0] acc_addrs[$];
    int            cyc = 0;
    int            lat = 3;
    int            wait_idx = -1;
    int            wait_len = 0;
    int            acc_cnt = 0;
    int            wait_cnt = 0;
    logic          clr = 1'b0;
    logic          stable_err = 1'b0;
    logic          seen_wait = 1'b0;
    logic          prev_wait = 1'b0;
    logic          en_seen = 1'b0;
    logic [AW-1:0] held_addr = '0;

    assign mem_waitreq = mem_rd_en && (acc_cnt == wait_idx) && (wait_cnt < wait_len);

    // Accept requests, track the stall burst, and return data after `lat`.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            acc_cnt    <= 0;
            wait_cnt   <= 0;
            stable_err <= 1'b0;
            seen_wait  <= 1'b0;
            prev_wait  <= 1'b0;
            en_seen    <= 1'b0;
            acc_addrs.delete();
        end else begin
            prev_wait <= mem_rd_en && mem_waitreq;
            if (mem_rd_en) en_seen <= 1'b1;
            if (prev_wait && !mem_rd_en) stable_err <= 1'b1;
            if (mem_rd_en && mem_waitreq) begin
                wait_cnt <= wait_cnt + 1;
                if (seen_wait && (mem_rd_addr != held_addr)) stable_err <= 1'b1;
                held_addr <= mem_rd_addr;
                seen_wait <= 1'b1;
            end
            if (mem_rd_en && !mem_waitreq) begin
                acc_cnt <= acc_cnt + 1;
                acc_addrs.push_back(mem_rd_addr);
                new_req.due  = cyc + lat;
                new_req.addr = mem_rd_addr;
                req_q.push_back(new_req);
            end
        end
        if ((req_q.size() > 0) && (req_q[0].due <= cyc)) begin
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= memData(req_q[0].addr);
            void'(req_q.pop_front());
        end else begin
            mem_rd_valid <= 1'b0;
        end
    end

    // ---------------- FIFO model ----------------
    int            fcount = 0;
    logic          fifo_rd = 1'b0;
    logic          ovf = 1'b0;
    logic [DW-1:0] wr_log[$];

    assign fifo_space = PW'(DEPTH - fcount);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcount <= 0;
        end else begin
            fcount <= fcount + (fifo_wr_en ? 1 : 0) - ((fifo_rd && fcount > 0) ? 1 : 0);
            if (clr) begin
                wr_log.delete();
                ovf <= 1'b0;
            end else if (fifo_wr_en) begin
                if (fcount >= DEPTH) ovf <= 1'b1;
                wr_log.push_back(fifo_wr_data);
            end
        end
    end

    // ---------------- tasks ----------------
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearLogs();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n    = 1'b0;
        go       = 1'b0;
        fifo_rd  = 1'b0;
        wait_idx = -1;
        wait_len = 0;
        lat      = 3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
    endtask

    task automatic applyStimulus(input logic [AW-1:0] a, input logic [SW-1:0] n);
        @(negedge clk);
        go      = 1'b1;
        rd_addr = a;
        size    = n;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !done; i++) @(negedge clk);
        checkOutput(tag, done, 1'b1);
    endtask

    task automatic checkData(input string tag, input logic [AW-1:0] base, input int n);
        int errs = 0;
        logic [AW-1:0] a;
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            a = base + AW'(i);
            if (wr_log[i] !== memData(a)) errs++;
        end
        checkOutput(tag, errs, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [AW-1:0] a;
        int seq_errs;

        // Reset values while rst_n is low.
        repeat (2) @(negedge clk);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rd_en", mem_rd_en, 0);
        checkOutput("rst_rd_addr", mem_rd_addr, 0);
        checkOutput("rst_wr_en", fifo_wr_en, 0);
        checkOutput("rst_wr_data", fifo_wr_data, 0);
        checkOutput("rst_stall", stall_cycles, 0);

        // Single word at 0x100.
        resetDut();
        applyStimulus(16'h0100, 1);
        waitDone("s1_done_timeout", 100);
        checkOutput("s1_req_cnt", acc_cnt, 1);
        checkOutput("s1_req_addr", acc_addrs.size() > 0 ? acc_addrs[0] : 16'hDEAD, 16'h0100);
        checkOutput("s1_wr_cnt", wr_log.size(), 1);
        checkData("s1_wr_data", 16'h0100, 1);
        checkOutput("s1_fifo_cnt", fcount, 1);
        checkOutput("s1_stall", stall_cycles, 0);

        // Wait-request burst of 5 cycles on the 3rd request.
        resetDut();
        wait_idx = 2;
        wait_len = 5;
        applyStimulus(16'h0020, 6);
        waitDone("wr_done_timeout", 200);
        checkOutput("wr_req_cnt", acc_cnt, 6);
        checkOutput("wr_wait_cnt", wait_cnt, 5);
        checkOutput("wr_stable", stable_err, 0);
        seq_errs = 0;
        for (int i = 0; i < acc_addrs.size(); i++) begin
            a = 16'h0020 + AW'(i);
            if (acc_addrs[i] !== a) seq_errs++;
        end
        checkOutput("wr_addr_seq", seq_errs, 0);
        checkOutput("wr_wr_cnt", wr_log.size(), 6);
        checkData("wr_wr_data", 16'h0020, 6);
        checkOutput("wr_stall", stall_cycles, EXP_WAIT_STALL);

        // Address wrap at the top of the address space.
        resetDut();
        applyStimulus(16'hFFFE, 4);
        waitDone("wrap_done_timeout", 100);
        checkOutput("wrap_req_cnt", acc_cnt, 4);
        checkOutput("wrap_a0", acc_addrs.size() > 0 ? acc_addrs[0] : 16'hDEAD, 16'hFFFE);
        checkOutput("wrap_a1", acc_addrs.size() > 1 ? acc_addrs[1] : 16'hDEAD, 16'hFFFF);
        checkOutput("wrap_a2", acc_addrs.size() > 2 ? acc_addrs[2] : 16'hDEAD, 16'h0000);
        checkOutput("wrap_a3", acc_addrs.size() > 3 ? acc_addrs[3] : 16'hDEAD, 16'h0001);
        checkData("wrap_wr_data", 16'hFFFE, 4);

        // Zero-length transfer completes immediately with no requests.
        resetDut();
        applyStimulus(16'h0200, 0);
        checkOutput("z_done", done, 1);
        repeat (5) @(negedge clk);
        checkOutput("z_no_req", en_seen, 0);
        checkOutput("z_wr_cnt", wr_log.size(), 0);

        // A second go while transferring is ignored.
        resetDut();
        applyStimulus(16'h0300, 8);
        @(negedge clk);
        applyStimulus(16'h0500, 20);
        waitDone("g2_done_timeout", 200);
        repeat (5) @(negedge clk);
        checkOutput("g2_req_cnt", acc_cnt, 8);
        checkOutput("g2_last_addr", acc_addrs.size() > 7 ? acc_addrs[7] : 16'hDEAD, 16'h0307);
        checkOutput("g2_wr_cnt", wr_log.size(), 8);

        // Long transfer against a FIFO that is not read for 2000 cycles.
        resetDut();
        applyStimulus(16'h1000, 1000);
        repeat (2000) @(negedge clk);
        checkOutput("big_wr_stop", wr_log.size(), DEPTH);
        checkOutput("big_req_stop", acc_cnt, DEPTH);
        checkOutput("big_rd_en_off", mem_rd_en, 0);
        checkOutput("big_done_early", done, 0);
        fifo_rd = 1'b1;
        waitDone("big_done_timeout", 5000);
        checkOutput("big_wr_cnt", wr_log.size(), 1000);
        checkOutput("big_ovf", ovf, 0);
        checkData("big_wr_data", 16'h1000, 1000);
        fifo_rd = 1'b0;

        // Reset during DRAIN with three responses still owed.
        resetDut();
        lat = 10;
        applyStimulus(16'h0040, 4);
        for (int i = 0; i < 100 && !(acc_cnt == 4 && req_q.size() == 3); i++) @(negedge clk);
        checkOutput("rd_outstanding", req_q.size(), 3);
        rst_n = 1'b0;
        #1;
        checkOutput("rd_rst_done", done, 0);
        checkOutput("rd_rst_rd_en", mem_rd_en, 0);
        checkOutput("rd_rst_addr", mem_rd_addr, 0);
        checkOutput("rd_rst_wr_en", fifo_wr_en, 0);
        checkOutput("rd_rst_wr_data", fifo_wr_data, 0);
        checkOutput("rd_rst_stall", stall_cycles, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
        repeat (30) @(negedge clk);
        checkOutput("rd_late_drained", req_q.size(), 0);
        checkOutput("rd_late_no_wr", wr_log.size(), 0);
        checkOutput("rd_late_no_req", en_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
